button_io: RTL

Memory-mapped push-button peripheral sitting between the board buttons and the processor bus. Synchronises and debounces up to four buttons, emits one-cycle press pulses to neighbouring blocks (mouse sensitivity controls), latches press events into a bus-readable register, and raises a level interrupt to the processor until acknowledged. It replaces the ad-hoc button debounce logic in the system top.

---
 rtl/button_io_pkg.sv | 18 +
 rtl/button_io_if.sv | 29 ++
 rtl/button_io_debounce.sv | 51 +++++
 rtl/button_io.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/button_io_pkg.sv
// button_io_pkg: constants and types shared by the button_io slice.
//   STATE_OFS/EVENTS_OFS/MASK_OFS : register offsets from BASE_ADDR
//   irq_state_t                   : interrupt FSM states
//   MAX_BTN                       : largest supported button count
package button_io_pkg;

  localparam int unsigned MAX_BTN = 4;

  localparam logic [7:0] STATE_OFS  = 8'd0;
  localparam logic [7:0] EVENTS_OFS = 8'd1;
  localparam logic [7:0] MASK_OFS   = 8'd2;

  typedef enum logic {
    IDLE,
    RAISED
  } irq_state_t;

endpackage

// File: rtl/button_io_if.sv
// button_io_if: processor-side control signals of the button peripheral.
//   BUS_ADDR            : bus address
//   BUS_WE              : bus write enable
//   BUS_INTERRUPT_RAISE : level interrupt request to the processor
//   BUS_INTERRUPT_ACK   : one-cycle acknowledge from the processor
// The 8-bit data bus is a shared tristate net and stays a plain inout port
// on the peripheral.
interface button_io_if;

  logic [7:0] BUS_ADDR;
  logic       BUS_WE;
  logic       BUS_INTERRUPT_RAISE;
  logic       BUS_INTERRUPT_ACK;

  modport master (
    output BUS_ADDR,
    output BUS_WE,
    output BUS_INTERRUPT_ACK,
    input  BUS_INTERRUPT_RAISE
  );

  modport slave (
    input  BUS_ADDR,
    input  BUS_WE,
    input  BUS_INTERRUPT_ACK,
    output BUS_INTERRUPT_RAISE
  );

endinterface

// File: rtl/button_io_debounce.sv
// button_debounce: synchroniser + debounce for one button.
//   CLK, RESET : clock, synchronous active-high reset
//   BTN_RAW    : raw asynchronous button level
//   LEVEL      : debounced level
//   RISE/FALL  : combinational strobes, high in the cycle before LEVEL flips
//                up/down (so they coincide with the flipping edge)
// A level change is accepted after DEB_CYCLES consecutive differing samples.
module button_debounce #(
  parameter int unsigned DEB_CYCLES = 50000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic BTN_RAW,
  output logic LEVEL,
  output logic RISE,
  output logic FALL
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          flip;

  assign flip = (sync2 != LEVEL) && (cnt == CNT_LAST);
  assign RISE = flip & sync2;
  assign FALL = flip & ~sync2;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      LEVEL <= 1'b0;
    end else begin
      sync1 <= BTN_RAW;
      sync2 <= sync1;
      if ((sync2 == LEVEL) || flip) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (flip) begin
        LEVEL <= ~LEVEL;
      end
    end
  end

endmodule

// File: rtl/button_io.sv
// button_io: memory-mapped push-button peripheral.
//   CLK, RESET : clock, synchronous active-high reset
//   BTN_IN     : raw button levels (NUM_BTN bits, active-high)
//   BTN_PULSE  : one-cycle pulse per accepted press
//   BUS_DATA   : shared data bus, driven only the cycle after a read here
//   bus        : address / write enable / interrupt raise / ack
// Registers at BASE_ADDR+0 STATE (RO), +1 EVENTS (W1C), +2 IRQ_MASK (RW).
// Optional macro BUTTON_IO_RELEASE_EVT_EN: release flips set EVENTS[4+i]
// and IRQ_MASK[7:4] gates their interrupts.
module button_io
  import button_io_pkg::*;
#(
  parameter int unsigned NUM_BTN    = 2,
  parameter int unsigned DEB_CYCLES = 50000,
  parameter logic [7:0]  BASE_ADDR  = 8'hC0
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_BTN-1:0] BTN_IN,
  output logic [NUM_BTN-1:0] BTN_PULSE,
  inout  wire  [7:0]         BUS_DATA,
  button_io_if.slave         bus
);

`ifdef BUTTON_IO_RELEASE_EVT_EN
  localparam logic [7:0] MASK_BITS = 8'hFF;
`else
  localparam logic [7:0] MASK_BITS = 8'h0F;
`endif

  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] fall;
  logic [7:0]         set_bits;
  logic [7:0]         state_val;
  logic [7:0]         events;
  logic [7:0]         irq_mask;
  logic [7:0]         rd_data;
  logic [7:0]         rd_sel;
  logic               rd_valid;
  logic [7:0]         ofs;
  logic               in_win;
  logic               evt_pend;
  logic               retrig;
  irq_state_t         st;
  irq_state_t         st_nx;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .CLK    (CLK),
      .RESET  (RESET),
      .BTN_RAW(BTN_IN[i]),
      .LEVEL  (level[i]),
      .RISE   (rise[i]),
      .FALL   (fall[i])
    );
  end

  always_comb begin
    set_bits                = '0;
    set_bits[NUM_BTN-1:0]   = rise;
`ifdef BUTTON_IO_RELEASE_EVT_EN
    set_bits[4 +: NUM_BTN]  = fall;
`endif
    state_val               = '0;
    state_val[NUM_BTN-1:0]  = level;
  end

`ifndef BUTTON_IO_RELEASE_EVT_EN
  logic unused_fall;
  assign unused_fall = |fall;
`endif

  // Subtracting the base keeps the window check correct even if it wraps.
  assign ofs    = bus.BUS_ADDR - BASE_ADDR;
  assign in_win = (ofs < 8'd3);

  always_comb begin
    rd_sel = '0;
    case (ofs)
      STATE_OFS:  rd_sel = state_val;
      EVENTS_OFS: rd_sel = events;
      MASK_OFS:   rd_sel = irq_mask;
      default:    rd_sel = '0;
    endcase
  end

  assign BUS_DATA = rd_valid ? rd_data : 'z;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      BTN_PULSE <= '0;
      events    <= '0;
      irq_mask  <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      evt_pend  <= 1'b0;
    end else begin
      BTN_PULSE <= rise;
      // W1C applied first, then new events OR'd in: a set always wins.
      if (bus.BUS_WE && (ofs == EVENTS_OFS)) begin
        events <= (events & ~BUS_DATA) | set_bits;
      end else begin
        events <= events | set_bits;
      end
      if (bus.BUS_WE && (ofs == MASK_OFS)) begin
        irq_mask <= BUS_DATA & MASK_BITS;
      end
      rd_valid <= in_win && !bus.BUS_WE;
      rd_data  <= rd_sel;
      // Only freshly set events can request an interrupt.
      evt_pend <= |(set_bits & irq_mask);
    end
  end

  // An event arriving together with the ack is remembered one cycle so the
  // line drops for exactly one cycle and then re-raises.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      st     <= IDLE;
      retrig <= 1'b0;
    end else begin
      st     <= st_nx;
      retrig <= (st == RAISED) && bus.BUS_INTERRUPT_ACK && evt_pend;
    end
  end

  always_comb begin
    st_nx = st;
    case (st)
      IDLE:    if (evt_pend || retrig) st_nx = RAISED;
      RAISED:  if (bus.BUS_INTERRUPT_ACK) st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  assign bus.BUS_INTERRUPT_RAISE = (st == RAISED);

endmodule
